// File: rtl/gcd_arbiter_if.sv
// Request/response bundle between GCD clients and the shared gcd_arbiter engine.
// Carries rsp_cycles_o only when GCD_ARBITER_STATS_EN is defined.
interface gcd_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]         req_valid_i;
    logic [NREQ-1:0]         req_ready_o;
    logic [NREQ*XLEN-1:0]    req_a_i;
    logic [NREQ*XLEN-1:0]    req_b_i;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [XLEN-1:0]         rsp_gcd_o;
    logic [$clog2(NREQ)-1:0] rsp_id_o;
    logic                    busy_o;
`ifdef GCD_ARBITER_STATS_EN
    logic [15:0]             rsp_cycles_o;
`endif

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
`ifdef GCD_ARBITER_STATS_EN
        output rsp_cycles_o,
`endif
        output req_ready_o, rsp_valid_o, rsp_gcd_o, rsp_id_o, busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
`ifdef GCD_ARBITER_STATS_EN
        input  rsp_cycles_o,
`endif
        input  req_ready_o, rsp_valid_o, rsp_gcd_o, rsp_id_o, busy_o
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one binary (Stein) GCD engine among NREQ requesters.
// Optional CALC-cycle statistics output enabled by defining GCD_ARBITER_STATS_EN.
module gcd_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 4
) (
    input logic          clk_i,
    input logic          reset_i,
    gcd_arbiter_if.slave bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned KW  = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_a, r_b, r_result;
    logic [XLEN-1:0] w_a_nxt, w_b_nxt, w_result_nxt;
    logic [KW-1:0]   r_k, w_k_nxt;
    logic [IDW-1:0]  r_id, r_rr_ptr, w_id_nxt, w_rr_nxt;
    logic [IDW-1:0]  w_grant, w_idx;
    logic            w_grant_vld;
    logic [NREQ-1:0] w_req_ready;
    logic [XLEN-1:0] w_opa, w_opb;
`ifdef GCD_ARBITER_STATS_EN
    logic [15:0]     r_cycles, w_cycles_nxt;
`endif

    // First valid requester at or after rr_ptr, with wrap-around.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            w_idx = IDW'((int'(r_rr_ptr) + i) % int'(NREQ));
            if (!w_grant_vld && bus.req_valid_i[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == StIdle && !reset_i && w_grant_vld) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    assign w_opa = bus.req_a_i[int'(w_grant) * int'(XLEN) +: XLEN];
    assign w_opb = bus.req_b_i[int'(w_grant) * int'(XLEN) +: XLEN];

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_k_nxt      = r_k;
        w_result_nxt = r_result;
        w_id_nxt     = r_id;
        w_rr_nxt     = r_rr_ptr;
`ifdef GCD_ARBITER_STATS_EN
        w_cycles_nxt = r_cycles;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_grant_vld) begin
                    w_a_nxt  = w_opa;
                    w_b_nxt  = w_opb;
                    w_k_nxt  = '0;
                    w_id_nxt = w_grant;
                    w_rr_nxt = IDW'((int'(w_grant) + 1) % int'(NREQ));
`ifdef GCD_ARBITER_STATS_EN
                    w_cycles_nxt = '0;
`endif
                    if (w_opa == '0 || w_opb == '0) begin
                        w_result_nxt = w_opa | w_opb;
                        w_state_nxt  = StDone;
                    end else begin
                        w_state_nxt = StCalc;
                    end
                end
            end
            StCalc: begin
`ifdef GCD_ARBITER_STATS_EN
                if (r_cycles != 16'hFFFF) begin
                    w_cycles_nxt = r_cycles + 16'd1;
                end
`endif
                if (!r_a[0] && !r_b[0]) begin
                    w_a_nxt = r_a >> 1;
                    w_b_nxt = r_b >> 1;
                    w_k_nxt = r_k + KW'(1);
                end else if (!r_a[0]) begin
                    w_a_nxt = r_a >> 1;
                end else if (!r_b[0]) begin
                    w_b_nxt = r_b >> 1;
                end else if (r_a == r_b) begin
                    w_result_nxt = r_a << r_k;
                    w_state_nxt  = StDone;
                end else if (r_a > r_b) begin
                    w_a_nxt = r_a - r_b;
                end else begin
                    w_b_nxt = r_b - r_a;
                end
            end
            StDone: begin
                if (bus.rsp_ready_i) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_result <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
`ifdef GCD_ARBITER_STATS_EN
            r_cycles <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_k      <= w_k_nxt;
            r_result <= w_result_nxt;
            r_id     <= w_id_nxt;
            r_rr_ptr <= w_rr_nxt;
`ifdef GCD_ARBITER_STATS_EN
            r_cycles <= w_cycles_nxt;
`endif
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.rsp_valid_o = (r_state == StDone);
    assign bus.rsp_gcd_o   = r_result;
    assign bus.rsp_id_o    = r_id;
    assign bus.busy_o      = (r_state != StIdle);
`ifdef GCD_ARBITER_STATS_EN
    assign bus.rsp_cycles_o = r_cycles;
`endif
endmodule
